// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and state type for the SHA-256 message padder
package sha256_pkg;

    localparam int          WORDS_PER_BLOCK = 16;
    localparam logic [3:0]  LEN_IDX_HI      = 4'd14;
    localparam logic [3:0]  LEN_IDX_LO      = 4'd15;
    localparam logic [31:0] PAD_MARKER      = 32'h8000_0000;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/sha256_last_word_pad.sv
// rtl/sha256_last_word_pad.sv - keeps the valid bytes of a final word and appends the 0x80 marker
module sha256_last_word_pad
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] word
);

    // Bytes past the valid count are replaced by the marker and zeros; 4 or more passes the word through
    always_comb begin
        word = data;
        case (nbytes)
            3'd0:    word = PAD_MARKER;
            3'd1:    word = {data[31:24], 24'h80_0000};
            3'd2:    word = {data[31:16], 16'h8000};
            3'd3:    word = {data[31:8],  8'h80};
            default: word = data;
        endcase
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - packs a word stream into FIPS 180-4 padded 512-bit SHA-256 blocks
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int LENBITS  = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WORDSIZE-1:0]                 s_data,
    input  logic [2:0]                          s_nbytes,
    input  logic                                s_last,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [WORDSIZE*WORDS_PER_BLOCK-1:0] M,
    output logic                                M_valid,
    input  logic                                M_ready,
    output logic                                first_block,
    output logic                                last_block
);

    state_e                              state_q, state_d;
    logic [3:0]                          idx_q, idx_d;
    logic [LENBITS-1:0]                  cnt_q, cnt_d;
    logic [WORDSIZE*WORDS_PER_BLOCK-1:0] m_q, m_d;
    logic                                m_valid_q, m_valid_d;
    logic                                first_q, first_d;
    logic                                last_q, last_d;
    logic                                marker_q, marker_d;     // 0x80 still owed (message ended on a full word)
    logic                                ovf_q, ovf_d;           // marker left no room for the length in this block
    logic                                pad_active_q, pad_active_d;  // message closed, padding not yet emitted

    logic [WORDSIZE-1:0] pad_word;
    logic                nbytes_full;
    logic [2:0]          eff_nbytes;
    logic [LENBITS-1:0]  len_bits;

    sha256_last_word_pad u_last_word_pad (
        .data   (s_data),
        .nbytes (s_nbytes),
        .word   (pad_word)
    );

    assign nbytes_full = !s_last || (s_nbytes >= 3'd4);
    assign eff_nbytes  = nbytes_full ? 3'd4 : s_nbytes;
    assign len_bits    = {cnt_q[LENBITS-4:0], 3'b000};

    assign s_ready     = rst_n && (state_q == FILL);
    assign M           = m_q;
    assign M_valid     = m_valid_q;
    assign first_block = first_q;
    assign last_block  = last_q;

    // Next-state logic: fill from the stream, pad one word per cycle, hold the block until taken
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        m_d          = m_q;
        m_valid_d    = m_valid_q;
        first_d      = first_q;
        last_d       = last_q;
        marker_d     = marker_q;
        ovf_d        = ovf_q;
        pad_active_d = pad_active_q;

        case (state_q)
            FILL: begin
                if (s_valid) begin
                    m_d[{~idx_q, 5'd0} +: WORDSIZE] = s_last ? pad_word : s_data;
                    cnt_d = cnt_q + {{(LENBITS-3){1'b0}}, eff_nbytes};
                    idx_d = idx_q + 4'd1;
                    if (s_last) begin
                        pad_active_d = 1'b1;
                        marker_d     = nbytes_full;
                        ovf_d        = !nbytes_full && (idx_q >= LEN_IDX_HI);
                        state_d      = PAD;
                    end
                    // A full block always goes out first, even if padding is still owed
                    if (idx_q == LEN_IDX_LO) begin
                        state_d   = EMIT;
                        m_valid_d = 1'b1;
                        last_d    = 1'b0;
                    end
                end
            end

            PAD: begin
                idx_d = idx_q + 4'd1;
                if (marker_q) begin
                    m_d[{~idx_q, 5'd0} +: WORDSIZE] = PAD_MARKER;
                    marker_d = 1'b0;
                    ovf_d    = (idx_q >= LEN_IDX_HI);
                end else if (!ovf_q && (idx_q == LEN_IDX_HI)) begin
                    m_d[{~idx_q, 5'd0} +: WORDSIZE] = len_bits[LENBITS-1:32];
                end else if (!ovf_q && (idx_q == LEN_IDX_LO)) begin
                    m_d[{~idx_q, 5'd0} +: WORDSIZE] = len_bits[31:0];
                end else begin
                    m_d[{~idx_q, 5'd0} +: WORDSIZE] = '0;
                end
                if (idx_q == LEN_IDX_LO) begin
                    state_d   = EMIT;
                    m_valid_d = 1'b1;
                    last_d    = !marker_q && !ovf_q;
                end
            end

            EMIT: begin
                if (M_ready) begin
                    m_valid_d = 1'b0;
                    idx_d     = 4'd0;
                    first_d   = 1'b0;
                    ovf_d     = 1'b0;
                    if (last_q) begin
                        state_d      = FILL;
                        first_d      = 1'b1;
                        last_d       = 1'b0;
                        cnt_d        = '0;
                        pad_active_d = 1'b0;
                    end else if (pad_active_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    // State registers; reset abandons any partial block or message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            idx_q        <= 4'd0;
            cnt_q        <= '0;
            m_q          <= '0;
            m_valid_q    <= 1'b0;
            first_q      <= 1'b1;
            last_q       <= 1'b0;
            marker_q     <= 1'b0;
            ovf_q        <= 1'b0;
            pad_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            m_q          <= m_d;
            m_valid_q    <= m_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            marker_q     <= marker_d;
            ovf_q        <= ovf_d;
            pad_active_q <= pad_active_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized self-checking bench for sha256_msg_padder
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_data;
    logic [2:0]   s_nbytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] M;
    logic         M_valid;
    logic         M_ready;
    logic         first_block;
    logic         last_block;

    sha256_msg_padder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_nbytes    (s_nbytes),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .M           (M),
        .M_valid     (M_valid),
        .M_ready     (M_ready),
        .first_block (first_block),
        .last_block  (last_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] m;
        bit           first;
        bit           last;
    } blk_t;

    blk_t       exp_q[$];
    blk_t       got_q[$];
    logic [7:0] msg[$];
    int         errors = 0;
    int         checks = 0;
    bit         mr_force = 1'b1;
    bit         mr_val   = 1'b0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] m, input int i);
        return m[(15-i)*32 +: 32];
    endfunction

    // Reference: byte-level FIPS 180-4 padding of the whole message, then cut into 64-byte blocks
    task automatic model_push();
        logic [7:0]  p[$];
        logic [63:0] bits;
        blk_t        b;
        int          nblk;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            b.m = '0;
            for (int j = 0; j < 64; j++) b.m[511-8*j -: 8] = p[64*k+j];
            b.first = (k == 0);
            b.last  = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        repeat (len) msg.push_back(8'($urandom));
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    // Drives msg as words; tail_empty closes a multiple-of-4 message with an extra 0-byte word
    task automatic send_msg(input bit tail_empty);
        int          len, nwords, nb, n;
        logic [31:0] d;
        len = msg.size();
        if (len == 0 || (len % 4 == 0 && tail_empty)) nwords = len / 4 + 1;
        else nwords = (len + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            if ($urandom % 4 == 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(posedge clk); #1;
            end
            for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (4*w + b < len) ? msg[4*w + b] : 8'($urandom);
            nb       = len - 4*w;
            s_data   = d;
            s_last   = (w == nwords - 1);
            s_nbytes = s_last ? 3'(nb) : 3'($urandom);
            s_valid  = 1'b1;
            n = 0;
            while (1) begin
                @(negedge clk);
                if (s_ready) break;
                n++;
                if (n > 300) begin
                    check("s_ready_timeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Core side: forced level or random backpressure, updated after the bench's own input writes
    always @(posedge clk) begin
        #2;
        M_ready = mr_force ? mr_val : ($urandom % 3 != 0);
    end

    // Every cycle a block is presented it must equal the head of the reference queue
    always @(negedge clk) begin
        if (rst_n === 1'b1 && M_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_block", 1, 0);
            end else begin
                check("blk_M", M, exp_q[0].m);
                check("blk_first", first_block, exp_q[0].first);
                check("blk_last", last_block, exp_q[0].last);
                check("s_ready_busy", s_ready, 0);
                if (M_ready) begin
                    got_q.push_back('{m: M, first: first_block, last: last_block});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        check("global_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int           n;
        logic [511:0] held;
        blk_t         b;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_nbytes = '0; s_last = 1'b0; M_ready = 1'b0;
        #12;
        check("rst_M_valid", M_valid, 0);
        check("rst_first", first_block, 1);
        check("rst_last", last_block, 0);
        check("rst_M", M, 0);
        check("rst_s_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // "abc" with latency measurement
        mr_force = 1'b1; mr_val = 1'b0;
        set_abc();
        model_push();
        check("model_abc_w0", word_of(exp_q[0].m, 0), 32'h61626380);
        check("model_abc_w15", word_of(exp_q[0].m, 15), 32'h18);
        got_q.delete();
        send_msg(1'b0);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (M_valid) break;
        end
        check("abc_latency", n, 15);
        mr_val = 1'b1;
        wait_done();
        check("abc_nblk", got_q.size(), 1);
        if (got_q.size() > 0) begin
            b = got_q[0];
            check("abc_w0", word_of(b.m, 0), 32'h61626380);
            for (int i = 1; i < 15; i++) check("abc_wz", word_of(b.m, i), 0);
            check("abc_w15", word_of(b.m, 15), 32'h18);
            check("abc_first", b.first, 1);
            check("abc_last", b.last, 1);
        end

        // Empty message
        mr_force = 1'b0;
        got_q.delete();
        rand_msg(0);
        model_push();
        send_msg(1'b0);
        wait_done();
        check("empty_nblk", got_q.size(), 1);
        if (got_q.size() > 0) begin
            b = got_q[0];
            check("empty_w0", word_of(b.m, 0), 32'h80000000);
            check("empty_rest", b.m[479:0], 0);
            check("empty_flags", {b.first, b.last}, 2'b11);
        end

        // 55 bytes
        got_q.delete();
        rand_msg(55);
        model_push();
        send_msg(1'b0);
        wait_done();
        check("b55_nblk", got_q.size(), 1);
        if (got_q.size() > 0) begin
            b = got_q[0];
            check("b55_w13_lo", b.m[(15-13)*32 +: 8], 8'h80);
            check("b55_w14", word_of(b.m, 14), 0);
            check("b55_w15", word_of(b.m, 15), 32'h1B8);
        end

        // 56 bytes, full last word: length spills into a second block
        got_q.delete();
        rand_msg(56);
        model_push();
        send_msg(1'b0);
        wait_done();
        check("b56_nblk", got_q.size(), 2);
        if (got_q.size() > 1) begin
            b = got_q[0];
            check("b56_b1_w14", word_of(b.m, 14), 32'h80000000);
            check("b56_b1_w15", word_of(b.m, 15), 0);
            check("b56_b1_flags", {b.first, b.last}, 2'b10);
            b = got_q[1];
            check("b56_b2_zero", b.m[511:64], 0);
            check("b56_b2_w15", word_of(b.m, 15), 32'h1C0);
            check("b56_b2_flags", {b.first, b.last}, 2'b01);
        end

        // 64 bytes with the core stalling for 10 cycles
        mr_force = 1'b1; mr_val = 1'b0;
        got_q.delete();
        rand_msg(64);
        model_push();
        send_msg(1'b0);
        n = 0;
        while (!M_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b64_valid_seen", M_valid, 1);
        held = M;
        repeat (10) begin
            @(posedge clk); #1;
            check("b64_hold_valid", M_valid, 1);
            check("b64_hold_M", M, held);
            check("b64_hold_s_ready", s_ready, 0);
        end
        mr_val = 1'b1;
        wait_done();
        check("b64_nblk", got_q.size(), 2);
        if (got_q.size() > 1) begin
            b = got_q[1];
            check("b64_b2_w0", word_of(b.m, 0), 32'h80000000);
            check("b64_b2_w15", word_of(b.m, 15), 32'h200);
        end

        // Reset pulse while padding: nothing may come out
        mr_force = 1'b1; mr_val = 1'b0;
        got_q.delete();
        rand_msg(5);
        send_msg(1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_M_valid", M_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_first", first_block, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mr_force = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_block", got_q.size(), 0);
        set_abc();
        model_push();
        send_msg(1'b0);
        wait_done();
        check("midrst_abc_nblk", got_q.size(), 1);
        if (got_q.size() > 0) begin
            b = got_q[0];
            check("midrst_abc_w0", word_of(b.m, 0), 32'h61626380);
            check("midrst_abc_w15", word_of(b.m, 15), 32'h18);
            check("midrst_abc_first", b.first, 1);
        end

        // Lengths around the one/two block boundary, both tail encodings
        for (int len = 52; len <= 68; len++) begin
            rand_msg(len);
            model_push();
            send_msg(1'($urandom));
            wait_done();
        end

        // Random lengths
        repeat (20) begin
            rand_msg($urandom_range(0, 160));
            model_push();
            send_msg(1'($urandom));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
